rfblackwidow_dcinv_ctrl: RTL and testbench

//  Initiator side of the data-cache invalidate interface. Queues invalidate commands
//  (line/all/range) from the memory pipeline and CACHE instructions, sequences them into

---
 rtl/rfblackwidow_dcinv_ctrl_pkg.sv | 36 +++
 rtl/rfblackwidow_dcinv_ctrl_fifo.sv | 51 +++++
 rtl/rfblackwidow_dcinv_ctrl.sv | 160 ++++++++++++++++
 tb/tb_rfblackwidow_dcinv_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfblackwidow_dcinv_ctrl_pkg.sv
// Shared types and constants for the data-cache invalidate initiator.
// Build option: RFBW_DCINV_RANGE_EN adds the line-walking RANGE state.
package rfblackwidow_dcinv_ctrl_pkg;

    localparam int DC_AWID       = 32;
    localparam int DC_LINES      = 128;
    localparam int DC_LINE_SHIFT = 7;

    typedef enum logic [1:0] {
        DCI_LINE  = 2'd0,
        DCI_ALL   = 2'd1,
        DCI_RANGE = 2'd2
    } dcinv_cmd_t;

    typedef struct packed {
        dcinv_cmd_t          cmd;
        logic [DC_AWID-1:0]  adr;
        logic [DC_AWID-1:0]  end_adr;
    } dcinv_req_t;

`ifdef RFBW_DCINV_RANGE_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LINE,
        ST_ALL,
        ST_RANGE
    } dcinv_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LINE,
        ST_ALL
    } dcinv_state_t;
`endif

endpackage

// File: rtl/rfblackwidow_dcinv_ctrl_fifo.sv
// Synchronous command FIFO for invalidate requests; DEPTH must be a power of 2.
// Push is ignored when full and pop is ignored when empty.
module rfblackwidow_dcinv_ctrl_fifo
    import rfblackwidow_dcinv_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  dcinv_req_t push_data,
    input  logic       pop,
    output dcinv_req_t head,
    output logic       full,
    output logic       empty
);
    localparam int PW = $clog2(DEPTH);

    dcinv_req_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + (PW+1)'(1);
            else if (!do_push && do_pop) count <= count - (PW+1)'(1);
        end
    end

    // Entry storage needs no reset: occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rfblackwidow_dcinv_ctrl.sv
// Data-cache invalidate initiator: queues LINE/ALL/RANGE commands and issues
// invce/invline/invall strobes, retrying any cycle lost to a fill write (dc_wr).
// Build option: RFBW_DCINV_RANGE_EN walks RANGE line by line; otherwise RANGE runs as ALL.
module rfblackwidow_dcinv_ctrl
    import rfblackwidow_dcinv_ctrl_pkg::*;
#(
    parameter int AWID       = DC_AWID,
    parameter int QDEPTH     = 4,
    parameter int LINES      = DC_LINES,
    parameter int LINE_SHIFT = DC_LINE_SHIFT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_v,
    output logic            req_rdy,
    input  logic [1:0]      req_cmd,
    input  logic [AWID-1:0] req_adr,
    input  logic [AWID-1:0] req_end_adr,
    input  logic            dc_wr,
    output logic            invce,
    output logic            invline,
    output logic            invall,
    output logic [AWID-1:0] inv_adr,
    output logic            busy,
    output logic            done
);
    localparam logic [AWID-1:0] LINE_MASK = ~AWID'((1 << LINE_SHIFT) - 1);

    dcinv_req_t      push_data;
    dcinv_req_t      head;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    dcinv_state_t    state;
    dcinv_state_t    state_nxt;
    logic [AWID-1:0] cur;
    logic [AWID-1:0] cur_nxt;
    logic [AWID-1:0] head_start;
    logic            done_nxt;

`ifdef RFBW_DCINV_RANGE_EN
    logic [AWID-1:0] head_end;
    logic [AWID-1:0] end_q;
    logic [AWID-1:0] end_nxt;
    logic            span_wide;

    assign head_end  = head.end_adr & LINE_MASK;
    assign span_wide = ((head_end - head_start) >> LINE_SHIFT) >= AWID'(LINES - 1);
`else
    logic unused_end_adr;

    assign unused_end_adr = ^head.end_adr;
`endif

    assign push_data = '{cmd: dcinv_cmd_t'(req_cmd), adr: req_adr, end_adr: req_end_adr};
    assign push      = req_v & ~full & (req_cmd != 2'd3);
    assign req_rdy   = ~full;
    assign pop       = (state == ST_IDLE) & ~empty;
    assign head_start = head.adr & LINE_MASK;

    rfblackwidow_dcinv_ctrl_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // State, walk address and done pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cur   <= '0;
            done  <= 1'b0;
`ifdef RFBW_DCINV_RANGE_EN
            end_q <= '0;
`endif
        end else begin
            state <= state_nxt;
            cur   <= cur_nxt;
            done  <= done_nxt;
`ifdef RFBW_DCINV_RANGE_EN
            end_q <= end_nxt;
`endif
        end
    end

    // Sequencer: pop a command in IDLE, hold while dc_wr steals the valid array.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        done_nxt  = 1'b0;
`ifdef RFBW_DCINV_RANGE_EN
        end_nxt   = end_q;
`endif
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    cur_nxt = head_start;
                    case (head.cmd)
                        DCI_LINE: state_nxt = ST_LINE;
                        DCI_ALL:  state_nxt = ST_ALL;
                        DCI_RANGE: begin
`ifdef RFBW_DCINV_RANGE_EN
                            if (head_end < head_start) begin
                                end_nxt   = head_start;
                                state_nxt = ST_RANGE;
                            end else if (span_wide) begin
                                state_nxt = ST_ALL;
                            end else begin
                                end_nxt   = head_end;
                                state_nxt = ST_RANGE;
                            end
`else
                            state_nxt = ST_ALL;
`endif
                        end
                        default: state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_LINE, ST_ALL: begin
                if (!dc_wr) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
`ifdef RFBW_DCINV_RANGE_EN
            ST_RANGE: begin
                if (!dc_wr) begin
                    if (cur == end_q) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        cur_nxt = cur + AWID'(1 << LINE_SHIFT);
                    end
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign invce   = (state != ST_IDLE);
    assign invall  = (state == ST_ALL);
`ifdef RFBW_DCINV_RANGE_EN
    assign invline = (state == ST_LINE) | (state == ST_RANGE);
`else
    assign invline = (state == ST_LINE);
`endif
    assign inv_adr = invline ? cur : '0;
    assign busy    = ~empty | (state != ST_IDLE);

endmodule

// File: tb/tb_rfblackwidow_dcinv_ctrl.sv
// Self-checking bench for rfblackwidow_dcinv_ctrl: directed cases with literal
// expectations plus randomized traffic compared against a command-level model.
// Honours RFBW_DCINV_RANGE_EN the same way as the design.
module tb_rfblackwidow_dcinv_ctrl;

    logic        clk;
    logic        rst;
    logic        req_v;
    logic        req_rdy;
    logic [1:0]  req_cmd;
    logic [31:0] req_adr;
    logic [31:0] req_end_adr;
    logic        dc_wr;
    logic        invce;
    logic        invline;
    logic        invall;
    logic [31:0] inv_adr;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;

    rfblackwidow_dcinv_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_v       (req_v),
        .req_rdy     (req_rdy),
        .req_cmd     (req_cmd),
        .req_adr     (req_adr),
        .req_end_adr (req_end_adr),
        .dc_wr       (dc_wr),
        .invce       (invce),
        .invline     (invline),
        .invall      (invall),
        .inv_adr     (inv_adr),
        .busy        (busy),
        .done        (done)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: pending commands, and the strobe list of the active one.
    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] adr;
        logic [31:0] end_adr;
    } cmd_t;

    typedef struct {
        bit          all;
        logic [31:0] adr;
    } issue_t;

    cmd_t   cq[$];
    issue_t iq[$];
    bit     m_active;
    bit     m_done;
    bit     model_ok;

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & 32'hFFFF_FF80;
    endfunction

    // Turn one command into the ordered list of strobes it must produce.
    function automatic void expand(input cmd_t c);
        issue_t      it;
        logic [31:0] s;
        logic [31:0] e;
        longint      n;
        s = align(c.adr);
        e = align(c.end_adr);
        it.all = 1'b0;
        it.adr = s;
        if (c.cmd == 2'd0) begin
            iq.push_back(it);
        end else if (c.cmd == 2'd1) begin
            it.all = 1'b1;
            iq.push_back(it);
        end else begin
`ifdef RFBW_DCINV_RANGE_EN
            if (e < s) begin
                iq.push_back(it);
            end else begin
                n = (longint'({32'b0, e}) - longint'({32'b0, s})) / 128 + 1;
                if (n >= 128) begin
                    it.all = 1'b1;
                    iq.push_back(it);
                end else begin
                    for (longint i = 0; i < n; i++) begin
                        it.adr = s + 32'(i * 128);
                        iq.push_back(it);
                    end
                end
            end
`else
            it.all = 1'b1;
            iq.push_back(it);
`endif
        end
    endfunction

    // Advance the model once per clock using the inputs the DUT sees.
    always @(posedge clk) begin
        int   sz0;
        bit   new_done;
        cmd_t c;
        if (rst) begin
            cq.delete();
            iq.delete();
            m_active = 1'b0;
            m_done   = 1'b0;
            model_ok = 1'b1;
        end else begin
            sz0      = cq.size();
            new_done = 1'b0;
            if (m_active) begin
                if (!dc_wr) begin
                    void'(iq.pop_front());
                    if (iq.size() == 0) begin
                        m_active = 1'b0;
                        new_done = 1'b1;
                    end
                end
            end else if (sz0 > 0) begin
                expand(cq.pop_front());
                m_active = 1'b1;
            end
            if (req_v && sz0 < 4 && req_cmd != 2'd3) begin
                c.cmd     = req_cmd;
                c.adr     = req_adr;
                c.end_adr = req_end_adr;
                cq.push_back(c);
            end
            m_done = new_done;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] cmd, input logic [31:0] adr,
                                 input logic [31:0] end_adr, input logic wr);
        req_v       = v;
        req_cmd     = cmd;
        req_adr     = adr;
        req_end_adr = end_adr;
        dc_wr       = wr;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            checkOutput("invce",   invce,   m_active);
            checkOutput("invline", invline, m_active && !iq[0].all);
            checkOutput("invall",  invall,  m_active && iq[0].all);
            checkOutput("done",    done,    m_done);
            checkOutput("busy",    busy,    (cq.size() > 0) || m_active);
            checkOutput("req_rdy", req_rdy, cq.size() < 4);
            if (m_active && !iq[0].all) checkOutput("inv_adr", inv_adr, iq[0].adr);
        end
    end

    // Offer one command at a negedge, wait for acceptance, then drop req_v.
    task automatic pushCmd(input logic [1:0] cmd, input logic [31:0] adr, input logic [31:0] end_adr);
        int tries;
        req_v       = 1'b1;
        req_cmd     = cmd;
        req_adr     = adr;
        req_end_adr = end_adr;
        tries = 0;
        while (!req_rdy && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 50) checkOutput("push_timeout", 32'(tries), 0);
        @(negedge clk);
        req_v = 1'b0;
    endtask

    // Count strobes over a window of negedges starting at the current one.
    task automatic observe(input int cycles, output int n_ce, output int n_done,
                           output int n_all, output logic [31:0] first_adr);
        n_ce = 0;
        n_done = 0;
        n_all = 0;
        first_adr = 32'hFFFF_FFFF;
        for (int i = 0; i < cycles; i++) begin
            if (invce) n_ce++;
            if (done) n_done++;
            if (invall) n_all++;
            if (invline && first_adr == 32'hFFFF_FFFF) first_adr = inv_adr;
            @(negedge clk);
        end
    endtask

    initial begin
        int          n_ce;
        int          n_done;
        int          n_all;
        int          t;
        int          r;
        int          mode;
        logic [1:0]  cmd;
        logic [31:0] a;
        logic [31:0] e;
        logic [31:0] fa;

        vectors     = 0;
        miscompares = 0;
        model_ok    = 1'b0;
        rst         = 1'b1;
        applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset state");
        checkOutput("rst_invce", invce, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_req_rdy", req_rdy, 1);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_inv_adr", inv_adr, 0);

        $display("[TB] single LINE");
        pushCmd(2'd0, 32'h0000_1280, 32'h0);
        checkOutput("t1_n1_invce", invce, 0);
        @(negedge clk);
        checkOutput("t1_n2_invce", invce, 1);
        checkOutput("t1_n2_invline", invline, 1);
        checkOutput("t1_n2_adr", inv_adr, 32'h1280);
        @(negedge clk);
        checkOutput("t1_n3_invce", invce, 0);
        checkOutput("t1_n3_done", done, 1);
        @(negedge clk);
        checkOutput("t1_n4_done", done, 0);

        $display("[TB] RANGE walk");
        pushCmd(2'd2, 32'h1000, 32'h1100);
        @(negedge clk);
`ifdef RFBW_DCINV_RANGE_EN
        checkOutput("t2_adr0", inv_adr, 32'h1000);
        @(negedge clk);
        checkOutput("t2_adr1", inv_adr, 32'h1080);
        @(negedge clk);
        checkOutput("t2_adr2", inv_adr, 32'h1100);
        checkOutput("t2_invline", invline, 1);
`else
        checkOutput("t2_invall", invall, 1);
`endif
        @(negedge clk);
        checkOutput("t2_done", done, 1);
        checkOutput("t2_idle", invce, 0);
        @(negedge clk);

        $display("[TB] RANGE with fill collision");
        pushCmd(2'd2, 32'h1000, 32'h1080);
        @(negedge clk);
        checkOutput("t3_first", invce, 1);
        dc_wr = 1'b1;
        @(negedge clk);
        dc_wr = 1'b0;
`ifdef RFBW_DCINV_RANGE_EN
        checkOutput("t3_held_adr", inv_adr, 32'h1000);
`else
        checkOutput("t3_held_all", invall, 1);
`endif
        observe(6, n_ce, n_done, n_all, fa);
`ifdef RFBW_DCINV_RANGE_EN
        checkOutput("t3_invce_total", 32'(1 + n_ce), 3);
`else
        checkOutput("t3_invce_total", 32'(1 + n_ce), 2);
`endif
        checkOutput("t3_done_cnt", 32'(n_done), 1);

        $display("[TB] FIFO fill under dc_wr");
        dc_wr = 1'b1;
        for (int i = 0; i < 5; i++) pushCmd(2'd0, 32'h3000 + 32'(i * 128), 32'h0);
        checkOutput("t4_full_rdy", req_rdy, 0);
        checkOutput("t4_busy", busy, 1);
        dc_wr = 1'b0;
        observe(16, n_ce, n_done, n_all, fa);
        checkOutput("t4_invce_cnt", 32'(n_ce), 5);
        checkOutput("t4_done_cnt", 32'(n_done), 5);
        checkOutput("t4_first_adr", fa, 32'h3000);

        $display("[TB] range boundaries");
        pushCmd(2'd2, 32'h0, 32'h4000);
        observe(6, n_ce, n_done, n_all, fa);
        checkOutput("t5_wide_ce", 32'(n_ce), 1);
        checkOutput("t5_wide_all", 32'(n_all), 1);
        checkOutput("t5_wide_done", 32'(n_done), 1);
        pushCmd(2'd2, 32'h2000, 32'h1000);
        observe(6, n_ce, n_done, n_all, fa);
        checkOutput("t5_rev_ce", 32'(n_ce), 1);
`ifdef RFBW_DCINV_RANGE_EN
        checkOutput("t5_rev_all", 32'(n_all), 0);
        checkOutput("t5_rev_adr", fa, 32'h2000);
`else
        checkOutput("t5_rev_all", 32'(n_all), 1);
`endif

        $display("[TB] reset mid-command");
        dc_wr = 1'b1;
        pushCmd(2'd2, 32'h1000, 32'h1300);
        t = 0;
        while (!invce && t < 20) begin
            @(negedge clk);
            t++;
        end
        checkOutput("t6_started", invce, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dc_wr = 1'b0;
        checkOutput("t6_invce", invce, 0);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_req_rdy", req_rdy, 1);
        checkOutput("t6_done", done, 0);
        @(negedge clk);
        checkOutput("t6_done_after", done, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 9);
            cmd = (r < 5) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            a = $urandom();
            mode = $urandom_range(0, 9);
            if (mode < 7)      e = a + 32'($urandom_range(0, 5) * 128) + 32'($urandom_range(0, 127));
            else if (mode < 8) e = a - 32'($urandom_range(128, 4096));
            else               e = a + 32'($urandom_range(124, 132) * 128);
            applyStimulus(1'($urandom_range(0, 1)), cmd, a, e, ($urandom_range(0, 9) < 3));
            @(negedge clk);
        end

        applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
        t = 0;
        while (busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checkOutput("drain_busy", busy, 0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
